// File: rtl/pip_hazard_unit.sv
// pip_hazard_unit: forwarding selects, load-use stall, branch flush FSM and hazard-cycle counter
module pip_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_ad,
  input  logic [4:0]       id_rs2_ad,
  input  logic [4:0]       ex_rs1_ad,
  input  logic [4:0]       ex_rs2_ad,
  input  logic [4:0]       ex_rd_ad,
  input  logic             ex_rdEn,
  input  logic             ex_DMread,
  input  logic [4:0]       mem_rd_ad,
  input  logic             mem_rdEn,
  input  logic             mem_DMread,
  input  logic [4:0]       wb_rd_ad,
  input  logic             wb_rdEn,
  input  logic             branch_taken,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             hold_pc,
  output logic             hold_ifid,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hz_count
);
  typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic w_mem_ok, w_wb_ok, w_memA, w_memB, w_wbA, w_wbB, w_lu, w_any;
  // a load still in MEM has no result yet; only ALU results forward from EX/MEM
  assign w_mem_ok = mem_rdEn & ~mem_DMread & (mem_rd_ad != 5'd0);
  assign w_wb_ok  = wb_rdEn & (wb_rd_ad != 5'd0);
  assign w_memA   = w_mem_ok & (mem_rd_ad == ex_rs1_ad);
  assign w_memB   = w_mem_ok & (mem_rd_ad == ex_rs2_ad);
  assign w_wbA    = w_wb_ok & (wb_rd_ad == ex_rs1_ad);
  assign w_wbB    = w_wb_ok & (wb_rd_ad == ex_rs2_ad);
  assign fwdA = rst ? 2'b00 : w_memA ? 2'b10 : w_wbA ? 2'b01 : 2'b00;
  assign fwdB = rst ? 2'b00 : w_memB ? 2'b10 : w_wbB ? 2'b01 : 2'b00;
  assign w_lu = ex_DMread & ex_rdEn & (ex_rd_ad != 5'd0) &
                ((ex_rd_ad == id_rs1_ad) | (ex_rd_ad == id_rs2_ad));
  always_comb begin
    w_next     = RUN;
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    if (rst) begin
      w_next = RUN;
    end else if (r_state == FLUSH) begin
      flush_ifid = 1'b1;
      bubble_ex  = branch_taken;
      w_next     = branch_taken ? FLUSH : RUN;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      bubble_ex  = 1'b1;
      w_next     = FLUSH;
    end else if (w_lu) begin
      hold_pc   = 1'b1;
      hold_ifid = 1'b1;
      bubble_ex = 1'b1;
    end
  end
  assign w_any = hold_pc | bubble_ex | flush_ifid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_any && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign state    = r_state;
  assign hz_count = r_cnt;
endmodule

// File: tb/tb_pip_hazard_unit.sv
// tb_pip_hazard_unit: randomized scoreboard bench against a rule-level reference model
module tb_pip_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, mem_rd_ad, wb_rd_ad;
  logic ex_rdEn, ex_DMread, mem_rdEn, mem_DMread, wb_rdEn, branch_taken;
  logic [1:0] fwdA, fwdB, state;
  logic hold_pc, hold_ifid, bubble_ex, flush_ifid;
  logic [3:0] hz_count;
  typedef struct {
    logic [4:0] id1, id2, ex1, ex2, exrd, memrd, wbrd;
    logic exen, exld, memen, memld, wben, br;
  } stim_t;
  typedef struct {
    logic [1:0] fa, fb, st;
    logic hp, hi, bx, fl;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  event mon_ev;
  int checks = 0;
  int errors = 0;
  logic m_flush = 1'b0;
  int m_cnt = 0;
  logic last_rst = 1'b1, last_ctrl = 1'b0, last_br = 1'b0;
  pip_hazard_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
    .ex_rs1_ad(ex_rs1_ad), .ex_rs2_ad(ex_rs2_ad),
    .ex_rd_ad(ex_rd_ad), .ex_rdEn(ex_rdEn), .ex_DMread(ex_DMread),
    .mem_rd_ad(mem_rd_ad), .mem_rdEn(mem_rdEn), .mem_DMread(mem_DMread),
    .wb_rd_ad(wb_rd_ad), .wb_rdEn(wb_rdEn), .branch_taken(branch_taken),
    .fwdA(fwdA), .fwdB(fwdB), .hold_pc(hold_pc), .hold_ifid(hold_ifid),
    .bubble_ex(bubble_ex), .flush_ifid(flush_ifid), .state(state), .hz_count(hz_count)
  );
  always #5 clk = ~clk;
  function automatic stim_t z();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction
  function automatic logic [1:0] sel(input stim_t s, input logic [4:0] rs);
    if (s.memen && !s.memld && s.memrd != 0 && s.memrd == rs) return 2'd2;
    if (s.wben && s.wbrd != 0 && s.wbrd == rs) return 2'd1;
    return 2'd0;
  endfunction
  function automatic exp_t model(input stim_t s, input logic r, input logic f, input int c);
    exp_t e;
    logic lu;
    e = '{default: 0};
    if (r) return e;
    e.fa = sel(s, s.ex1);
    e.fb = sel(s, s.ex2);
    lu = s.exld && s.exen && s.exrd != 0 && (s.exrd == s.id1 || s.exrd == s.id2);
    e.st = {1'b0, f};
    e.cnt = 4'(c);
    if (f) begin
      e.fl = 1; e.bx = s.br;
    end else if (s.br) begin
      e.fl = 1; e.bx = 1;
    end else if (lu) begin
      e.hp = 1; e.hi = 1; e.bx = 1;
    end
    return e;
  endfunction
  task automatic apply(input stim_t s, input logic r);
    id_rs1_ad = s.id1; id_rs2_ad = s.id2; ex_rs1_ad = s.ex1; ex_rs2_ad = s.ex2;
    ex_rd_ad = s.exrd; ex_rdEn = s.exen; ex_DMread = s.exld;
    mem_rd_ad = s.memrd; mem_rdEn = s.memen; mem_DMread = s.memld;
    wb_rd_ad = s.wbrd; wb_rdEn = s.wben; branch_taken = s.br; rst = r;
  endtask
  task automatic cycle(input stim_t s, input logic r);
    exp_t e;
    @(posedge clk); #1;
    if (last_rst) begin
      m_flush = 0; m_cnt = 0;
    end else begin
      m_flush = last_br;
      if (last_ctrl && m_cnt < 15) m_cnt = m_cnt + 1;
    end
    apply(s, r);
    e = model(s, r, m_flush, m_cnt);
    q.push_back(e);
    last_ctrl = e.hp | e.bx | e.fl;
    last_br = s.br;
    last_rst = r;
  endtask
  task automatic async_pulse();
    stim_t s;
    exp_t e;
    @(negedge clk); #2;
    s = z(); s.br = 1; s.exld = 1; s.exen = 1; s.exrd = 7; s.id1 = 7;
    s.memrd = 3; s.memen = 1; s.ex1 = 3; s.wbrd = 4; s.wben = 1; s.ex2 = 4;
    apply(s, 1'b1);
    #1;
    e = '{default: 0};
    q.push_back(e);
    ->mon_ev;
    #1;
    apply(z(), 1'b0);
    last_rst = 1; last_ctrl = 0; last_br = 0;
  endtask
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  always begin
    exp_t e;
    @(negedge clk or mon_ev);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwdA", fwdA, e.fa);
      chk("fwdB", fwdB, e.fb);
      chk("hold_pc", hold_pc, e.hp);
      chk("hold_ifid", hold_ifid, e.hi);
      chk("bubble_ex", bubble_ex, e.bx);
      chk("flush_ifid", flush_ifid, e.fl);
      chk("state", state, e.st);
      chk("hz_count", hz_count, e.cnt);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    stim_t s;
    apply(z(), 1'b1);
    cycle(z(), 1'b1);
    cycle(z(), 1'b1);
    s = z(); s.memrd = 5; s.memen = 1; s.wbrd = 5; s.wben = 1; s.ex1 = 5; s.ex2 = 3;
    cycle(s, 1'b0);
    s.memld = 1;
    cycle(s, 1'b0);
    s.memrd = 0; s.memld = 0; s.wbrd = 0;
    cycle(s, 1'b0);
    cycle(z(), 1'b1);
    s = z(); s.exld = 1; s.exen = 1; s.exrd = 7; s.id2 = 7;
    cycle(s, 1'b0);
    s = z(); s.memrd = 7; s.memen = 1; s.memld = 1;
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    s = z(); s.exld = 1; s.exen = 1; s.exrd = 0; s.id2 = 0; s.id1 = 0;
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    s = z(); s.exld = 1; s.exen = 1; s.exrd = 7; s.id1 = 7; s.br = 1;
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b0);
    s = z(); s.br = 1;
    cycle(s, 1'b0);
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b1);
    s = z(); s.exld = 1; s.exen = 1; s.exrd = 9; s.id1 = 9;
    repeat (20) cycle(s, 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b0);
    cycle(z(), 1'b1);
    s = z(); s.br = 1;
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    async_pulse();
    cycle(z(), 1'b0);
    cycle(z(), 1'b0);
    s = z(); s.exld = 1; s.exen = 1; s.exrd = 2; s.id2 = 2;
    cycle(s, 1'b0);
    cycle(z(), 1'b0);
    for (int i = 0; i < 400; i++) begin
      s.id1 = 5'($urandom_range(0, 7)); s.id2 = 5'($urandom_range(0, 7));
      s.ex1 = 5'($urandom_range(0, 7)); s.ex2 = 5'($urandom_range(0, 7));
      s.exrd = 5'($urandom_range(0, 7)); s.memrd = 5'($urandom_range(0, 7));
      s.wbrd = 5'($urandom_range(0, 7));
      s.exen = 1'($urandom); s.exld = 1'($urandom); s.memen = 1'($urandom);
      s.memld = 1'($urandom); s.wben = 1'($urandom);
      s.br = ($urandom_range(0, 5) == 0);
      cycle(s, $urandom_range(0, 39) == 0);
      if (i % 97 == 50) async_pulse();
    end
    cycle(z(), 1'b0);
    @(negedge clk); #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
